// File: rtl/pt226x_pkg.sv
// Shared types and constants for the PT2262 transmit scheduler: FSM states,
// trinary address digit encodings and default timing parameters.
package pt226x_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

  // Trinary digit as {A_F, A_01}; any digit with A_F set is a float.
  localparam logic [1:0] TRI_0 = 2'b00;
  localparam logic [1:0] TRI_1 = 2'b01;
  localparam logic [1:0] TRI_F = 2'b10;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_REPEAT     = 4;
  localparam int DEFAULT_GAP_CYCLES = 3000;
  localparam int DEFAULT_TIMEOUT    = 131072;

  // A_01 bit driven to the encoder is 1 only for a genuine '1' digit.
  function automatic logic [7:0] float_dominant_01(input logic [7:0] a01,
                                                   input logic [7:0] af);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      res[i] = ({af[i], a01[i]} == TRI_1);
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps,
// returning a one-hot winner and a valid flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         winner_o,
  output logic                       valid_o
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    winner_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
      if (!found && req_i[idx]) begin
        winner_o[idx] = 1'b1;
        found         = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/pt2262_tx_scheduler.sv
// Shares one PT2262 encoder between NUM_REQ requesters: latches the winning
// word, sends it REPEAT times, acks it, then holds the grant for a gap.
module pt2262_tx_scheduler
  import pt226x_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int REPEAT     = DEFAULT_REPEAT,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_A_01,
  input  logic [8*NUM_REQ-1:0]   req_A_F,
  input  logic [4*NUM_REQ-1:0]   req_D,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   err,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output logic [7:0]             enc_A_01,
  output logic [7:0]             enc_A_F,
  output logic [3:0]             enc_D,
  output logic                   enc_start,
  input  logic                   enc_busy,
  input  logic                   enc_done,
  output sched_state_e           dbg_state
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int REP_W = $clog2(REPEAT + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  sched_state_e       state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   owner_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               err_q;
  logic               busy_q;
  logic               start_q;
  logic [7:0]         a01_q;
  logic [7:0]         af_q;
  logic [3:0]         d_q;
  logic [REP_W-1:0]   rep_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [GAP_W-1:0]   gap_q;

  logic [NUM_REQ-1:0] winner;
  logic               win_valid;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   ptr_adv;
  logic [7:0]         sel_a01;
  logic [7:0]         sel_af;
  logic [3:0]         sel_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i    (req),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .valid_o  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    sel_a01 = '0;
    sel_af  = '0;
    sel_d   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) begin
        win_idx = PTR_W'(i);
        sel_a01 = req_A_01[8*i +: 8];
        sel_af  = req_A_F[8*i +: 8];
        sel_d   = req_D[4*i +: 4];
      end
    end
  end

  // The requester after the finished owner becomes highest priority.
  assign ptr_adv = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Encoder handshake: enc_start is a one-cycle strobe issued only while
  // enc_busy is low; the frame is complete on the single-cycle enc_done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      a01_q   <= '0;
      af_q    <= '0;
      d_q     <= '0;
      rep_q   <= '0;
      tmr_q   <= '0;
      gap_q   <= '0;
    end else begin
      ack_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (win_valid && !enc_busy) begin
            grant_q <= winner;
            owner_q <= win_idx;
            a01_q   <= float_dominant_01(sel_a01, sel_af);
            af_q    <= sel_af;
            d_q     <= sel_d;
            busy_q  <= 1'b1;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          if (!enc_busy) begin
            start_q <= 1'b1;
            tmr_q   <= '0;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A done arriving on the timeout cycle still counts as success.
          if (enc_done) begin
            if (rep_q == REP_LAST) begin
              ack_q   <= grant_q;
              rep_q   <= '0;
              ptr_q   <= ptr_adv;
              gap_q   <= '0;
              state_q <= ST_GAP;
            end else begin
              rep_q   <= rep_q + 1'b1;
              state_q <= ST_START;
            end
          end else if (tmr_q == TMR_LAST) begin
            err_q   <= 1'b1;
            rep_q   <= '0;
            ptr_q   <= ptr_adv;
            gap_q   <= '0;
            state_q <= ST_GAP;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (GAP_CYCLES == 0 || gap_q == GAP_LAST) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign err       = err_q;
  assign grant     = grant_q;
  assign busy      = busy_q;
  assign enc_A_01  = a01_q;
  assign enc_A_F   = af_q;
  assign enc_D     = d_q;
  assign enc_start = start_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pt2262_tx_scheduler.sv
// Directed bench for pt2262_tx_scheduler with a simple encoder model that
// answers each enc_start with enc_done a fixed number of cycles later.
module tb_pt2262_tx_scheduler;
  import pt226x_pkg::*;

  localparam int NUM_REQ  = 4;
  localparam int REPEAT   = 4;
  localparam int GAP      = 10;
  localparam int TIMEOUT  = 100;
  localparam int DONE_DLY = 20;

  logic                 clk;
  logic                 reset;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_A_01;
  logic [8*NUM_REQ-1:0] req_A_F;
  logic [4*NUM_REQ-1:0] req_D;
  logic [NUM_REQ-1:0]   ack;
  logic                 err;
  logic [NUM_REQ-1:0]   grant;
  logic                 busy;
  logic [7:0]           enc_A_01;
  logic [7:0]           enc_A_F;
  logic [3:0]           enc_D;
  logic                 enc_start;
  logic                 enc_busy;
  logic                 enc_done;
  sched_state_e         dbg_state;

  pt2262_tx_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .REPEAT     (REPEAT),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_A_01  (req_A_01),
    .req_A_F   (req_A_F),
    .req_D     (req_D),
    .ack       (ack),
    .err       (err),
    .grant     (grant),
    .busy      (busy),
    .enc_A_01  (enc_A_01),
    .enc_A_F   (enc_A_F),
    .enc_D     (enc_D),
    .enc_start (enc_start),
    .enc_busy  (enc_busy),
    .enc_done  (enc_done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_cmp, n_bad;
  logic [NUM_REQ-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- encoder model and monitor ----------------
  logic model_busy, hold_busy, done_en;
  int   model_cnt;
  assign enc_busy = model_busy | hold_busy;

  logic [7:0] t_a01[NUM_REQ];
  logic [7:0] t_af[NUM_REQ];
  logic [3:0] t_d[NUM_REQ];

  int start_cnt, ack_total, err_total, data_bad, ack_starts;
  int first_start_cyc, ack_cyc, err_cyc;
  int sb_total, mg_total;
  logic [NUM_REQ-1:0] ack_last;

  task automatic clear_mon();
    start_cnt = 0; ack_total = 0; err_total = 0; data_bad = 0; ack_starts = 0;
    first_start_cyc = 0; ack_cyc = 0; err_cyc = 0; ack_last = '0;
  endtask

  initial begin
    model_busy = 1'b0; model_cnt = 0; enc_done = 1'b0;
    sb_total = 0; mg_total = 0;
    clear_mon();
    forever begin
      @(negedge clk);
      if (enc_start && enc_busy) sb_total++;
      if (!$onehot0(grant)) mg_total++;
      if (enc_start) begin
        start_cnt++;
        if (start_cnt == 1) first_start_cyc = cyc;
        for (int i = 0; i < NUM_REQ; i++)
          if (grant[i] && {enc_A_01, enc_A_F, enc_D} !== {t_a01[i], t_af[i], t_d[i]}) data_bad++;
      end
      if (|ack) begin
        ack_total++; ack_last = ack; ack_cyc = cyc; ack_starts = start_cnt;
        if (exp_q.size() > 0) chk("ack_order", ack, exp_q.pop_front());
      end
      if (err) begin
        err_total++; err_cyc = cyc;
      end
      enc_done = 1'b0;
      if (!reset) begin
        model_busy = 1'b0;
      end else begin
        if (model_busy) begin
          model_cnt++;
          if (model_cnt == DONE_DLY) begin
            model_busy = 1'b0;
            enc_done   = done_en;
          end
        end
        if (enc_start) begin
          model_busy = 1'b1;
          model_cnt  = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a01, input logic [7:0] af,
                         input logic [3:0] d);
    req_A_01[8*i +: 8] = a01;
    req_A_F[8*i +: 8]  = af;
    req_D[4*i +: 4]    = d;
  endtask

  task automatic set_exp(input int i, input logic [7:0] a01, input logic [7:0] af,
                         input logic [3:0] d);
    t_a01[i] = a01; t_af[i] = af; t_d[i] = d;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; hold_busy = 1'b0; done_en = 1'b1;
    exp_q.delete();
    step(3);
    clear_mon();
    reset = 1'b1;
    step(1);
  endtask

  function automatic bit evt_done(input int sel, input int n);
    case (sel)
      0:       return ack_total >= n;
      1:       return err_total >= n;
      2:       return start_cnt >= n;
      default: return busy == 1'b0;
    endcase
  endfunction

  task automatic wait_evt(input int sel, input int n, input int budget);
    int k;
    k = 0;
    while (k < budget && !evt_done(sel, n)) begin
      step(1);
      k++;
    end
  endtask

  // ---------------- stimulus ----------------
  int req_cyc, rel_cyc, idle_cyc;

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b0; req = '0; hold_busy = 1'b0; done_en = 1'b1;
    req_A_01 = '0; req_A_F = '0; req_D = '0;
    for (int i = 0; i < NUM_REQ; i++) set_exp(i, 8'h00, 8'h00, 4'h0);

    // Reset state
    step(2);
    chk("rst_ctrl", {grant, busy, enc_start, ack, err}, 0);
    chk("rst_word", {enc_A_01, enc_A_F, enc_D}, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    reset = 1'b1;
    step(1);

    // Single request on requester 2
    clear_mon();
    set_req(2, 8'h0F, 8'hF0, 4'hA);
    set_exp(2, 8'h0F, 8'hF0, 4'hA);
    req_cyc = cyc;
    req = 4'b0100;
    wait_evt(0, 1, 400);
    chk("single_ack", ack_last, 4'b0100);
    chk("single_starts", ack_starts, REPEAT);
    chk("single_latency", first_start_cyc - req_cyc, 2);
    chk("single_word", {enc_A_01, enc_A_F, enc_D}, {8'h0F, 8'hF0, 4'hA});
    chk("single_data", data_bad, 0);
    chk("single_gap_grant", grant, 4'b0100);
    req = '0;
    wait_evt(3, 0, 50);
    idle_cyc = cyc;
    chk("single_gap_len", idle_cyc - ack_cyc, GAP);
    chk("single_ack_once", ack_total, 1);

    // Contention: requesters 0, 1, 3 from pointer 0
    do_reset();
    set_req(0, 8'h11, 8'h00, 4'h1); set_exp(0, 8'h11, 8'h00, 4'h1);
    set_req(1, 8'h22, 8'h00, 4'h2); set_exp(1, 8'h22, 8'h00, 4'h2);
    set_req(3, 8'h33, 8'h00, 4'h3); set_exp(3, 8'h33, 8'h00, 4'h3);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0001);
    req = 4'b1011;
    wait_evt(0, 4, 1500);
    req = '0;
    chk("cont_acks", ack_total, 4);
    chk("cont_pending", exp_q.size(), 0);
    chk("cont_data", data_bad, 0);
    chk("cont_starts", start_cnt, 4 * REPEAT);
    wait_evt(3, 0, 50);

    // Float dominance, and later input changes are ignored
    do_reset();
    set_req(1, 8'hFF, 8'h0F, 4'h5);
    set_exp(1, 8'hF0, 8'h0F, 4'h5);
    req = 4'b0010;
    wait_evt(2, 1, 20);
    set_req(1, 8'h00, 8'hAA, 4'h0);
    wait_evt(0, 1, 400);
    chk("float_a01", enc_A_01, 8'hF0);
    chk("float_af", enc_A_F, 8'h0F);
    chk("float_data", data_bad, 0);
    req = '0;
    wait_evt(3, 0, 50);

    // Watchdog: requester 0 never completes, requester 1 follows
    do_reset();
    set_req(0, 8'h01, 8'h00, 4'h7); set_exp(0, 8'h01, 8'h00, 4'h7);
    set_req(1, 8'h02, 8'h00, 4'h8); set_exp(1, 8'h02, 8'h00, 4'h8);
    done_en = 1'b0;
    req = 4'b0011;
    wait_evt(1, 1, 300);
    chk("wd_err", err_total, 1);
    chk("wd_delay", err_cyc - first_start_cyc, TIMEOUT);
    chk("wd_noack", ack_total, 0);
    chk("wd_gap_grant", grant, 4'b0001);
    req[0] = 1'b0;
    done_en = 1'b1;
    wait_evt(0, 1, 400);
    chk("wd_next_ack", ack_last, 4'b0010);
    chk("wd_err_once", err_total, 1);
    req = '0;
    wait_evt(3, 0, 50);

    // Busy gating in IDLE
    do_reset();
    set_req(3, 8'h5A, 8'h00, 4'hC); set_exp(3, 8'h5A, 8'h00, 4'hC);
    hold_busy = 1'b1;
    req = 4'b1000;
    step(50);
    chk("bg_nostart", start_cnt, 0);
    chk("bg_idle", busy, 1'b0);
    rel_cyc = cyc;
    hold_busy = 1'b0;
    wait_evt(2, 1, 10);
    chk("bg_latency", first_start_cyc - rel_cyc, 2);
    wait_evt(0, 1, 400);
    req = '0;
    wait_evt(3, 0, 50);

    // Busy rising while in START holds the strobe
    clear_mon();
    req = 4'b1000;
    step(1);
    hold_busy = 1'b1;
    step(10);
    chk("hold_nostart", start_cnt, 0);
    chk("hold_state", dbg_state, ST_START);
    rel_cyc = cyc;
    hold_busy = 1'b0;
    wait_evt(2, 1, 10);
    chk("hold_latency", first_start_cyc - rel_cyc, 1);
    wait_evt(0, 1, 400);
    chk("hold_ack", ack_last, 4'b1000);
    req = '0;
    wait_evt(3, 0, 50);

    // Asynchronous reset during the second frame
    do_reset();
    set_req(2, 8'hC3, 8'h00, 4'h9); set_exp(2, 8'hC3, 8'h00, 4'h9);
    req = 4'b0100;
    wait_evt(2, 2, 100);
    step(5);
    reset = 1'b0;
    #1;
    chk("rstmid_out", {grant, busy, enc_start, ack, err, enc_A_01, enc_A_F, enc_D}, 0);
    step(2);
    chk("rstmid_no_event", ack_total + err_total, 0);
    clear_mon();
    reset = 1'b1;
    wait_evt(0, 1, 400);
    chk("rstmid_ack", ack_last, 4'b0100);
    chk("rstmid_starts", ack_starts, REPEAT);
    req = '0;
    wait_evt(3, 0, 50);

    chk("never_start_busy", sb_total, 0);
    chk("never_multi_grant", mg_total, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pt2262_tx_scheduler.md
Name: pt2262_tx_scheduler

Overview:
- Round-robin scheduler that shares one PT2262-compatible encoder between NUM_REQ requesters.
- Each granted request is latched (trinary address + 4-bit data) and transmitted REPEAT times back-to-back, then acknowledged.
- An inter-word gap is inserted before the next grant.
- A per-frame watchdog aborts the word if the encoder stalls.
- Sits between application request logic and the encoder, in the encoder's clock domain (3 MHz).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REPEAT, 4, frames sent per granted word (1..15).
- GAP_CYCLES, 3000, idle clk cycles after a word before re-arbitration (0 = none).
- TIMEOUT, 131072, max clk cycles from enc_start to enc_done before abort.

Ports:
- clk  input  1  system clock, 3 MHz.
- reset  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  level request per requester; held until its ack.
- req_A_01  input  8*NUM_REQ  address digits 0/1 per requester (slice i = [8i+7:8i]).
- req_A_F  input  8*NUM_REQ  address digit-is-float flags per requester.
- req_D  input  4*NUM_REQ  data nibble per requester (slice i = [4i+3:4i]).
- ack  output  NUM_REQ  one-cycle pulse: word of requester i fully sent.
- err  output  1  one-cycle pulse: watchdog abort.
- grant  output  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  output  1  high in any state other than IDLE.
- enc_A_01  output  8  address 0/1 digits to encoder.
- enc_A_F  output  8  address float digits to encoder.
- enc_D  output  4  data to encoder.
- enc_start  output  1  one-cycle frame start strobe.
- enc_busy  input  1  encoder transmitting.
- enc_done  input  1  one-cycle pulse at end of frame (after sync).

Behaviour:
- Reset (async, reset=0): state IDLE; grant, ack, err, enc_start = 0; enc_A_01, enc_A_F, enc_D = 0; busy = 0; repeat and timer counters = 0; round-robin pointer = requester 0 highest priority.
- All outputs are registered.
- States: IDLE, START, WAIT, GAP.
- IDLE:
  - If any req and !enc_busy at edge k, pick the winner round-robin, starting at (last winner + 1) mod NUM_REQ.
  - At edge k, register grant, enc_D = req_D slice, enc_A_F = req_A_F slice, enc_A_01 = req_A_01 & ~req_A_F (float dominates). Go to START.
  - Data is latched once. Later changes on req_* are ignored until ack.
- START:
  - enc_start = 1 for exactly one cycle (the cycle after the state is entered).
  - Clear the timer, go to WAIT. Latency from req sampled to enc_start high: 2 edges.
- WAIT, timer increments every cycle:
  - enc_done with repeat_cnt = REPEAT-1: ack[winner] = 1 for one cycle, repeat_cnt cleared, advance RR pointer, go to GAP.
  - enc_done otherwise: repeat_cnt++, go to START, so frames are back-to-back with a 2-cycle turnaround.
  - Timer reaches TIMEOUT-1 without enc_done: err = 1 for one cycle, no ack, repeat_cnt cleared, advance RR pointer, go to GAP.
  - enc_done in the same cycle as timeout: done wins, no err.
- GAP:
  - grant stays asserted. Count GAP_CYCLES, then clear grant and go to IDLE.
  - GAP_CYCLES = 0 goes directly to IDLE on the next edge.
- Dropping req during a word does not abort it; the ack is still issued.
- A winner that still holds req after its ack is eligible again, at lowest priority.
- enc_start is never asserted while enc_busy = 1. In START with enc_busy = 1, hold START (enc_start = 0) until enc_busy = 0. The watchdog is not running in START.
- Reset mid-word: immediate return to the reset state. No ack or err is emitted.
- Counter widths: repeat_cnt = $clog2(REPEAT+1), timer = $clog2(TIMEOUT+1), gap = $clog2(GAP_CYCLES+1). No wrap is possible before the terminal compare.

Decomposition:
- Package pt226x_pkg:
  - scheduler state enum (IDLE, START, WAIT, GAP);
  - trinary digit encodings (0 = A_01 0 / A_F 0, 1 = A_01 1 / A_F 0, F = A_F 1);
  - default REPEAT and TIMEOUT constants.
- One sub-module, rr_arbiter: NUM_REQ req vector plus pointer in, one-hot winner plus valid out, combinational. The pointer update stays in the scheduler.

Test Plan:
- Single request: req[2]=1, A_01=8'h0F, A_F=8'hF0, D=4'hA, encoder model pulses done 20 cycles after start → 4 enc_start pulses, enc_A_01=8'h0F / enc_A_F=8'hF0 / enc_D=4'hA throughout, ack[2] once after the 4th done, GAP_CYCLES idle before busy drops.
- Contention: req = 4'b1011 continuously, pointer at 0 → grant order 0,1,3,0,… with one ack per word, never two grants at once.
- Watchdog: TIMEOUT=100, encoder never pulses done → err pulses at cycle 100 after enc_start, no ack, next requester granted after the gap.
- Busy gating: enc_busy held high 50 cycles at request time → no enc_start until enc_busy falls; first start 2 cycles later.
- Float dominance: A_01=8'hFF, A_F=8'h0F → enc_A_01=8'hF0, enc_A_F=8'h0F.
- Async reset asserted mid-WAIT (second frame) → all outputs 0 immediately; after release, a held req restarts with repeat 1 of 4.
